// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous, active-high reset
//   start  - request; accepted only in IDLE or DONE
//   op     - RISC-V funct3: 0=MUL 1=MULH 2=MULHSU 3=MULHU 4=DIV 5=DIVU 6=REM 7=REMU
//   srcA   - rs1 operand (multiplicand / dividend)
//   srcB   - rs2 operand (multiplier / divisor)
//   busy   - operation in progress (PREP, RUN, FIX)
//   done   - one-cycle pulse, result valid
//   result - final result, held until the next FIX->DONE edge or reset
//
// Every operation takes PREP + WIDTH RUN cycles + FIX, so done rises
// WIDTH+2 edges after the accepting edge regardless of op or operands.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_t;

  state_t               state;
  state_t               state_nxt;
  op_t                  op_q;
  logic [WIDTH-1:0]     a_q;       // raw srcA as accepted
  logic [WIDTH-1:0]     b_q;       // raw srcB as accepted
  logic [WIDTH-1:0]     m_q;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc;       // mul: {hi, lo/multiplier}; div: {rem, quot/dividend}
  logic                 neg_q;     // final result must be negated
  logic [CNT_W-1:0]     count;

  // Decode and PREP-stage magnitudes (from latched operands)
  logic                 is_div;
  logic                 is_rem;
  logic                 a_signed;
  logic                 b_signed;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 neg_prep;

  // Iteration datapath
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   div_next;

  // FIX-stage result
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quot;
  logic [WIDTH-1:0]     rem;
  logic                 div_zero;
  logic                 div_ovf;
  logic [WIDTH-1:0]     min_neg;
  logic [WIDTH-1:0]     fix_res;

  always_comb begin
    is_div   = op_q[2];
    is_rem   = op_q[2] & op_q[1];
    a_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
               (op_q == OP_DIV)  || (op_q == OP_REM);
    b_signed = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
    a_neg    = a_signed & a_q[WIDTH-1];
    b_neg    = b_signed & b_q[WIDTH-1];
    a_mag    = a_neg ? (~a_q + 1'b1) : a_q;
    b_mag    = b_neg ? (~b_q + 1'b1) : b_q;
    // Remainder takes the dividend's sign; products and quotients take the XOR.
    neg_prep = (op_q == OP_REM) ? a_neg : (a_neg ^ b_neg);
  end

  always_comb begin
    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? m_q : '0)};
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring division: shift next dividend bit into the partial
    // remainder and subtract the divisor if it fits (no borrow).
    div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, m_q};
    if (!div_trial[WIDTH])
      div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      div_next = {acc[2*WIDTH-2:0], 1'b0};
  end

  always_comb begin
    prod     = neg_q ? (~acc + 1'b1) : acc;
    quot     = acc[WIDTH-1:0];
    rem      = acc[2*WIDTH-1:WIDTH];
    min_neg  = {1'b1, {(WIDTH-1){1'b0}}};
    div_zero = (b_q == '0);
    div_ovf  = (a_q == min_neg) && (b_q == '1) &&
               ((op_q == OP_DIV) || (op_q == OP_REM));
    fix_res  = '0;
    if (!is_div) begin
      fix_res = (op_q == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end else if (div_zero) begin
      fix_res = is_rem ? a_q : '1;
    end else if (div_ovf) begin
      fix_res = is_rem ? '0 : min_neg;
    end else if (is_rem) begin
      fix_res = neg_q ? (~rem + 1'b1) : rem;
    end else begin
      fix_res = neg_q ? (~quot + 1'b1) : quot;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_PREP;
      S_PREP: begin
        busy      = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (count == CNT_W'(WIDTH - 1)) state_nxt = S_FIX;
      end
      S_FIX: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = start ? S_PREP : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= OP_MUL;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      acc    <= '0;
      neg_q  <= 1'b0;
      count  <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_q <= op_t'(op);
            a_q  <= srcA;
            b_q  <= srcB;
          end
        end
        S_PREP: begin
          acc   <= is_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
          m_q   <= is_div ? b_mag : a_mag;
          neg_q <= neg_prep;
          count <= '0;
        end
        S_RUN: begin
          acc   <= is_div ? div_next : mul_next;
          count <= count + 1'b1;
        end
        S_FIX: result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks;
  int passes;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .srcA   (srcA),
    .srcB   (srcB),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation and wait (bounded) for done. lat is the number of
  // rising edges after the accepting edge at which done is first seen, or -1.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; srcA = a; srcB = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    res = result;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 3'd0; srcA = '0; srcB = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passes++;
    checks++; if (result !== 32'h0) $display("FAIL reset_result got %h want 00000000", result); else passes++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [31:0] r;
    int lat;
    run_op(3'd0, 32'h00000007, 32'hFFFFFFFD, r, lat);
    checks++; if (lat != 34) $display("FAIL mul_latency got %0d want 34", lat); else passes++;
    checks++; if (r !== 32'hFFFFFFEB) $display("FAIL mul got %h want FFFFFFEB", r); else passes++;
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat);
    checks++; if (r !== 32'hFFFFFFFE) $display("FAIL mulhu got %h want FFFFFFFE", r); else passes++;
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat);
    checks++; if (r !== 32'h00000000) $display("FAIL mulh got %h want 00000000", r); else passes++;
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat);
    checks++; if (r !== 32'hFFFFFFFF) $display("FAIL mulhsu got %h want FFFFFFFF", r); else passes++;
    run_op(3'd1, 32'h80000000, 32'h80000000, r, lat);
    checks++; if (r !== 32'h40000000) $display("FAIL mulh_minneg got %h want 40000000", r); else passes++;
    run_op(3'd3, 32'h80000000, 32'h00000002, r, lat);
    checks++; if (r !== 32'h00000001) $display("FAIL mulhu_carry got %h want 00000001", r); else passes++;
  endtask

  task automatic test_div();
    logic [31:0] r;
    int lat;
    run_op(3'd4, 32'hFFFFFFF9, 32'h00000002, r, lat);
    checks++; if (lat != 34) $display("FAIL div_latency got %0d want 34", lat); else passes++;
    checks++; if (r !== 32'hFFFFFFFD) $display("FAIL div_neg7_2 got %h want FFFFFFFD", r); else passes++;
    run_op(3'd6, 32'hFFFFFFF9, 32'h00000002, r, lat);
    checks++; if (r !== 32'hFFFFFFFF) $display("FAIL rem_neg7_2 got %h want FFFFFFFF", r); else passes++;
    run_op(3'd5, 32'd100, 32'd7, r, lat);
    checks++; if (r !== 32'd14) $display("FAIL divu_100_7 got %h want 0000000e", r); else passes++;
    run_op(3'd7, 32'd100, 32'd7, r, lat);
    checks++; if (r !== 32'd2) $display("FAIL remu_100_7 got %h want 00000002", r); else passes++;
    run_op(3'd4, 32'h00000007, 32'hFFFFFFFE, r, lat);
    checks++; if (r !== 32'hFFFFFFFD) $display("FAIL div_7_neg2 got %h want FFFFFFFD", r); else passes++;
    run_op(3'd6, 32'h00000007, 32'hFFFFFFFE, r, lat);
    checks++; if (r !== 32'h00000001) $display("FAIL rem_7_neg2 got %h want 00000001", r); else passes++;
  endtask

  task automatic test_special();
    logic [31:0] r;
    int lat;
    run_op(3'd4, 32'h12345678, 32'h0, r, lat);
    checks++; if (r !== 32'hFFFFFFFF) $display("FAIL div_by_zero got %h want FFFFFFFF", r); else passes++;
    run_op(3'd5, 32'h12345678, 32'h0, r, lat);
    checks++; if (r !== 32'hFFFFFFFF) $display("FAIL divu_by_zero got %h want FFFFFFFF", r); else passes++;
    run_op(3'd6, 32'h12345678, 32'h0, r, lat);
    checks++; if (r !== 32'h12345678) $display("FAIL rem_by_zero got %h want 12345678", r); else passes++;
    run_op(3'd7, 32'h12345678, 32'h0, r, lat);
    checks++; if (r !== 32'h12345678) $display("FAIL remu_by_zero got %h want 12345678", r); else passes++;
    run_op(3'd6, 32'hFFFFFFFB, 32'h0, r, lat);
    checks++; if (r !== 32'hFFFFFFFB) $display("FAIL rem_neg_by_zero got %h want FFFFFFFB", r); else passes++;
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, r, lat);
    checks++; if (lat != 34) $display("FAIL ovf_latency got %0d want 34", lat); else passes++;
    checks++; if (r !== 32'h80000000) $display("FAIL div_overflow got %h want 80000000", r); else passes++;
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, r, lat);
    checks++; if (r !== 32'h00000000) $display("FAIL rem_overflow got %h want 00000000", r); else passes++;
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    @(negedge clk);
    start = 1'b1; op = 3'd0; srcA = 32'd3; srcB = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL midrst_done got %b want 0", done); else passes++;
    checks++; if (result !== 32'h0) $display("FAIL midrst_result got %h want 00000000", result); else passes++;
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) $display("FAIL midrst_no_done got activity=%b want 0", seen); else passes++;
  endtask

  task automatic test_handshake();
    int lat;
    @(negedge clk);
    start = 1'b1; op = 3'd0; srcA = 32'd6; srcB = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL hs_busy_after_accept got %b want 1", busy); else passes++;
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'd5; srcA = 32'd100; srcB = 32'd7;
    @(negedge clk);
    start = 1'b0; srcA = 32'd99;
    lat = -1;
    for (int i = 7; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    checks++; if (lat != 34) $display("FAIL hs_latency got %0d want 34", lat); else passes++;
    checks++; if (result !== 32'd42) $display("FAIL hs_ignored_start got %h want 0000002a", result); else passes++;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL hs_pulse got done=%b busy=%b want 0 0", done, busy); else passes++;
    checks++; if (result !== 32'd42) $display("FAIL hs_hold got %h want 0000002a", result); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int lat;
    run_op(3'd0, 32'd3, 32'd5, r, lat);
    checks++; if (r !== 32'd15) $display("FAIL b2b_first got %h want 0000000f", r); else passes++;
    // Still inside the DONE cycle: hold start with new operands.
    start = 1'b1; op = 3'd0; srcA = 32'h10; srcB = 32'h20;
    @(posedge clk); #1;
    start = 1'b0; srcA = 32'h0; srcB = 32'h0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_accept got busy=%b done=%b want 1 0", busy, done); else passes++;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    checks++; if (lat != 34) $display("FAIL b2b_latency got %0d want 34", lat); else passes++;
    checks++; if (result !== 32'h200) $display("FAIL b2b_second got %h want 00000200", result); else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_reset_mid_run();
    test_handshake();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
